// File: rtl/formal_random_stim_checker.sv
// formal_random_stim_checker
//
// Random-stimulus driver and output checker that sits beside a
// <design>_top_formal_verification wrapper. A start pulse begins a run.
// The checker holds the DUT in reset for RESET_CYCLES cycles. It then drives
// RUN_CYCLES vectors from a 32-bit Galois LFSR. On every compare cycle it
// checks the fabric outputs against the golden benchmark outputs. It reports
// pass/fail, a saturating mismatch count and the RUN-cycle index of the
// first mismatch.
//
// Build option:
//   STIM_STOP_ON_FAIL_EN - when defined, the first mismatch ends the run on
//                          the next edge and stim stays at the failing vector.
//                          When undefined, every run lasts RUN_CYCLES cycles
//                          and every mismatch is counted.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset; aborts any run
//   start          in   one-cycle pulse; accepted in IDLE and DONE only
//   dut_reset      out  reset driven into the DUT
//   stim           out  registered stimulus vector (NUM_IN bits)
//   gfpga_out      in   fabric outputs (NUM_OUT bits)
//   ref_out        in   golden benchmark outputs (NUM_OUT bits)
//   busy           out  high while in RST_SEQ or RUN
//   done           out  high in DONE until the next start or reset
//   pass           out  valid while done; 1 means zero mismatches
//   mismatch_count out  saturating count of mismatching compare cycles
//   fail_cycle     out  RUN-cycle index of first mismatch, all-ones if none

module formal_random_stim_checker #(
  parameter int          NUM_IN       = 10,
  parameter int          NUM_OUT      = 2,
  parameter int          RESET_CYCLES = 2,
  parameter int          RUN_CYCLES   = 7,
  parameter int          CMP_LAT      = 1,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1,
  parameter int          CNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               dut_reset,
  output logic [NUM_IN-1:0]  stim,
  input  logic [NUM_OUT-1:0] gfpga_out,
  input  logic [NUM_OUT-1:0] ref_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   mismatch_count,
  output logic [CNT_W-1:0]   fail_cycle
);

  localparam logic [31:0] TAPS    = 32'h80200003;
  // An all-zero seed would lock the LFSR, so zero is replaced by 1.
  localparam logic [31:0] SEED    = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam int          CYC_MAX = (RUN_CYCLES > RESET_CYCLES) ? RUN_CYCLES : RESET_CYCLES;
  localparam int          CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RST_SEQ,
    RUN,
    DONE
  } state_t;

  state_t            state_q;
  logic [CYC_W-1:0]  cnt_q;
  logic [31:0]       lfsr_q;
  logic              dutReset_q;
  logic [NUM_IN-1:0] stim_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [CNT_W-1:0]  mismatchCount_q;
  logic [CNT_W-1:0]  failCycle_q;

  logic [31:0]       lfsr_d;
  logic [CNT_W-1:0]  mismatchCount_d;
  logic              cmpEnable;
  logic              mismatchNow;
  logic              lastRunCycle;
  logic              stopEarly;

  // Next LFSR state. This is a left-shifting Galois form: the bit shifted out
  // of the top folds back through the tap mask. The mask has bit 0 set, so a
  // nonzero state can never step to zero.
  assign lfsr_d = {lfsr_q[30:0], 1'b0} ^ ({32{lfsr_q[31]}} & TAPS);

  // Comparison is only meaningful once the DUT has had CMP_LAT cycles to
  // respond to the vectors of this run.
  assign cmpEnable    = (state_q == RUN) && (int'(cnt_q) >= CMP_LAT);
  assign mismatchNow  = cmpEnable && (gfpga_out != ref_out);
  assign lastRunCycle = (cnt_q == CYC_W'(RUN_CYCLES - 1));

  // Mismatch count including this cycle's compare, held at all-ones once full.
  assign mismatchCount_d = (mismatchNow && !(&mismatchCount_q)) ?
                           mismatchCount_q + 1'b1 : mismatchCount_q;

  // Early termination on the first mismatch, only in the stop-on-fail build.
`ifdef STIM_STOP_ON_FAIL_EN
  assign stopEarly = mismatchNow;
`else
  assign stopEarly = 1'b0;
`endif

  // Run controller. The state and every output register are updated here
  // together, so the outputs always reflect the current state with no
  // decode glitches. The LFSR steps on the edge that enters each RUN cycle,
  // so in RUN cycle c stim holds vector c.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      lfsr_q          <= SEED;
      dutReset_q      <= 1'b1;
      stim_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      mismatchCount_q <= '0;
      failCycle_q     <= '1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q         <= RST_SEQ;
            cnt_q           <= '0;
            lfsr_q          <= SEED;
            dutReset_q      <= 1'b1;
            stim_q          <= '0;
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            mismatchCount_q <= '0;
            failCycle_q     <= '1;
          end
        end
        RST_SEQ: begin
          if (cnt_q == CYC_W'(RESET_CYCLES - 1)) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            dutReset_q <= 1'b0;
            lfsr_q     <= lfsr_d;
            stim_q     <= lfsr_d[NUM_IN-1:0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          mismatchCount_q <= mismatchCount_d;
          // A count of zero means this is the first mismatch of the run.
          if (mismatchNow && (mismatchCount_q == '0)) begin
            failCycle_q <= CNT_W'(cnt_q);
          end
          if (lastRunCycle || stopEarly) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (mismatchCount_d == '0);
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            lfsr_q <= lfsr_d;
            stim_q <= lfsr_d[NUM_IN-1:0];
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dut_reset      = dutReset_q;
  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_count = mismatchCount_q;
  assign fail_cycle     = failCycle_q;

endmodule

// File: tb/tb_formal_random_stim_checker.sv
// tb_formal_random_stim_checker
//
// Directed bench for formal_random_stim_checker. The bench has three
// instances that share clock, reset and start:
//   A: default parameters, with a controllable single-bit error on gfpga_out.
//   B: CNT_W=2, NUM_IN=4, LFSR_SEED=0, with the outputs always differing.
//   C: NUM_IN=32, LFSR_SEED=32'h40000000, RUN_CYCLES=4, with the outputs equal.
//      This seed drives the LFSR through its feedback taps from the start.
// Expected vectors are hand-computed from the left-shifting Galois step with
// tap mask 32'h80200003.

module tb_formal_random_stim_checker;

  logic        clock;
  logic        reset;
  logic        start;
  logic        flipA;

  logic [1:0]  refA, gfpgaA, refB, gfpgaB, refC, gfpgaC;

  logic        dutResetA, busyA, doneA, passA;
  logic [9:0]  stimA;
  logic [15:0] countA, failA;

  logic        dutResetB, busyB, doneB, passB;
  logic [3:0]  stimB;
  logic [1:0]  countB, failB;

  logic        dutResetC, busyC, doneC, passC;
  logic [31:0] stimC;
  logic [15:0] countC, failC;

  int checks;
  int failures;

  // Vector c of each run for instance A: (32'hACE1 << (c+1)), low 10 bits.
  logic [9:0]  expA [7] = '{10'h1C2, 10'h384, 10'h308, 10'h210, 10'h020, 10'h040, 10'h080};
  // Instance B starts from seed 1: 2, 4, ... (low 4 bits).
  logic [3:0]  expB [2] = '{4'h2, 4'h4};
  // Instance C: 0x40000000 -> 0x80000000 -> taps fold in from then on.
  logic [31:0] expC [4] = '{32'h80000000, 32'h80200003, 32'h80600005, 32'h80E00009};

`ifdef STIM_STOP_ON_FAIL_EN
  localparam int          T2_LEN       = 4;
  localparam logic [9:0]  T2_STIM_HELD = 10'h210;
  localparam logic [1:0]  B_FINAL_CNT  = 2'd1;
`else
  localparam int          T2_LEN       = 7;
  localparam logic [9:0]  T2_STIM_HELD = 10'h080;
  localparam logic [1:0]  B_FINAL_CNT  = 2'd3;
`endif

  assign refA   = 2'b10;
  assign gfpgaA = refA ^ {1'b0, flipA};
  assign refB   = 2'b01;
  assign gfpgaB = ~refB;
  assign refC   = 2'b11;
  assign gfpgaC = refC;

  formal_random_stim_checker dutA (
    .clock(clock), .reset(reset), .start(start),
    .dut_reset(dutResetA), .stim(stimA),
    .gfpga_out(gfpgaA), .ref_out(refA),
    .busy(busyA), .done(doneA), .pass(passA),
    .mismatch_count(countA), .fail_cycle(failA)
  );

  formal_random_stim_checker #(.NUM_IN(4), .LFSR_SEED(32'h0), .CNT_W(2)) dutB (
    .clock(clock), .reset(reset), .start(start),
    .dut_reset(dutResetB), .stim(stimB),
    .gfpga_out(gfpgaB), .ref_out(refB),
    .busy(busyB), .done(doneB), .pass(passB),
    .mismatch_count(countB), .fail_cycle(failB)
  );

  formal_random_stim_checker #(.NUM_IN(32), .LFSR_SEED(32'h40000000), .RUN_CYCLES(4)) dutC (
    .clock(clock), .reset(reset), .start(start),
    .dut_reset(dutResetC), .stim(stimC),
    .gfpga_out(gfpgaC), .ref_out(refC),
    .busy(busyC), .done(doneC), .pass(passC),
    .mismatch_count(countC), .fail_cycle(failC)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one cycle of inputs, then waits until just after the next rising
  // edge, where outputs are stable for checking.
  task automatic applyStimulus(input logic startVal, input logic resetVal, input logic flipVal);
    start = startVal;
    reset = resetVal;
    flipA = flipVal;
    @(posedge clock);
    #1;
  endtask

  // Single comparison point: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence: reset, clean run, mismatch runs, abort, rerun.
  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    reset    = 1'b1;
    flipA    = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rst_dut_reset", dutResetA, 1);
    checkOutput("rst_stim", stimA, 0);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_done", doneA, 0);
    checkOutput("rst_pass", passA, 0);
    checkOutput("rst_count", countA, 0);
    checkOutput("rst_fail_cycle", failA, 16'hFFFF);
    checkOutput("rst_fail_cycle_B", failB, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_busy", busyA, 0);

    // T1: clean run on A, saturation run on B, tap run on C
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      checkOutput("t1_rstseq_dut_reset", dutResetA, 1);
      checkOutput("t1_rstseq_busy", busyA, 1);
      checkOutput("t1_rstseq_stim", stimA, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    for (int c = 0; c < 7; c++) begin
      checkOutput("t1_run_stim", stimA, expA[c]);
      checkOutput("t1_run_dut_reset", dutResetA, 0);
      checkOutput("t1_run_busy", busyA, 1);
      if (c < 2) checkOutput("t5_stim_B", stimB, expB[c]);
      if (c < 4) checkOutput("tap_stim_C", stimC, expC[c]);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("t1_done", doneA, 1);
    checkOutput("t1_busy_end", busyA, 0);
    checkOutput("t1_pass", passA, 1);
    checkOutput("t1_count", countA, 0);
    checkOutput("t1_fail_cycle", failA, 16'hFFFF);
    checkOutput("t3_done_B", doneB, 1);
    checkOutput("t3_pass_B", passB, 0);
    checkOutput("t3_count_B", countB, B_FINAL_CNT);
    checkOutput("t3_fail_cycle_B", failB, 1);
    checkOutput("tap_done_C", doneC, 1);
    checkOutput("tap_pass_C", passC, 1);
    checkOutput("tap_stim_held_C", stimC, 32'h80E00009);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t1_done_hold", doneA, 1);

    // T2: single mismatch in RUN cycle 3
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2_done_cleared", doneA, 0);
    checkOutput("t2_dut_reset", dutResetA, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < T2_LEN; c++) begin
      checkOutput("t2_run_stim", stimA, expA[c]);
      applyStimulus(1'b0, 1'b0, c == 3);
    end
    checkOutput("t2_done", doneA, 1);
    checkOutput("t2_pass", passA, 0);
    checkOutput("t2_count", countA, 1);
    checkOutput("t2_fail_cycle", failA, 3);
    checkOutput("t2_stim_held", stimA, T2_STIM_HELD);

    // Mismatch in cycle 0 (before CMP_LAT) is ignored; one in the final cycle counts
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b0, 1'b0, (c == 0) || (c == 6));
    end
    checkOutput("lat_done", doneA, 1);
    checkOutput("lat_pass", passA, 0);
    checkOutput("lat_count", countA, 1);
    checkOutput("lat_fail_cycle", failA, 6);

    // A mismatch only in cycle 0 leaves the run passing
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b0, 1'b0, c == 0);
    end
    checkOutput("lat0_pass", passA, 1);
    checkOutput("lat0_count", countA, 0);

    // T4: reset during RUN cycle 4 aborts; partial mismatch from cycle 2 is discarded
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, c == 2);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t4_busy", busyA, 0);
    checkOutput("t4_done", doneA, 0);
    checkOutput("t4_dut_reset", dutResetA, 1);
    checkOutput("t4_stim", stimA, 0);
    checkOutput("t4_count", countA, 0);
    checkOutput("t4_fail_cycle", failA, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      checkOutput("t4_rerun_stim", stimA, expA[c]);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("t4_rerun_done", doneA, 1);
    checkOutput("t4_rerun_pass", passA, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
